fetch_stage: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline: owns the program counter, drives the word

---
 rtl/fetch_stage.sv | 121 ++++++++++++
 tb/tb_fetch_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC, addresses instruction memory and
// fills the IF/ID register; halts permanently on a misaligned or out-of-range fetch target.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic [31:0] imem_inst_i,
  output logic [31:0] pc_o,
  output logic [31:0] ifid_inst_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic        fetch_err_o
);

  typedef enum logic {RUN, HALT} state_e;

  localparam logic [32:0] PC_LIMIT = 33'(IMEM_DEPTH) * 33'd4;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic [31:0] pc_plus4;
  logic [31:0] tgt;
  logic        upd;
  logic        bubble;
  logic        tgt_bad;

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    err_d   = err_q;
    tgt     = pc_plus4;
    upd     = 1'b0;
    bubble  = 1'b0;
    tgt_bad = 1'b0;

    unique case (state_q)
      RUN: begin
        // Priority: redirect beats flush beats stall; a held PC is never re-checked.
        if (redirect_i) begin
          tgt    = redirect_pc_i;
          upd    = 1'b1;
          bubble = 1'b1;
        end else if (flush_i) begin
          upd    = !stall_i;
          bubble = 1'b1;
        end else if (!stall_i) begin
          upd = 1'b1;
        end

        tgt_bad = (tgt[1:0] != 2'b00) || ({1'b0, tgt} >= PC_LIMIT);

        if (upd && tgt_bad) begin
          state_d = HALT;
          err_d   = 1'b1;
          bubble  = 1'b1;
        end else if (upd) begin
          pc_d = tgt;
        end

        if (bubble) begin
          inst_d  = NOP_INST;
          pc4_d   = '0;
          valid_d = 1'b0;
        end else if (upd) begin
          inst_d  = imem_inst_i;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
        end
      end
      HALT: begin
        inst_d  = NOP_INST;
        pc4_d   = '0;
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
      default: state_d = HALT;
    endcase
  end

  assign pc_o         = pc_q;
  assign ifid_inst_o  = inst_q;
  assign ifid_pc4_o   = pc4_q;
  assign ifid_valid_o = valid_q;
  assign fetch_err_o  = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, flush, redirect, illegal targets
// and asynchronous reset, against a small combinational instruction-memory model.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_inst_i;
  logic [31:0] pc_o;
  logic [31:0] ifid_inst_o;
  logic [31:0] ifid_pc4_o;
  logic        ifid_valid_o;
  logic        fetch_err_o;

  int checks;
  int failures;

  localparam logic [31:0] NOP = 32'h0000_0000;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_DEPTH(256),
    .NOP_INST  (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_inst_i  (imem_inst_i),
    .pc_o         (pc_o),
    .ifid_inst_o  (ifid_inst_o),
    .ifid_pc4_o   (ifid_pc4_o),
    .ifid_valid_o (ifid_valid_o),
    .fetch_err_o  (fetch_err_o)
  );

  // Memory: two fixed words at 0 and 4, elsewhere a tag word encoding the address.
  always_comb begin
    if (pc_o == 32'h0)      imem_inst_i = 32'h2008_0005;
    else if (pc_o == 32'h4) imem_inst_i = 32'h2009_0007;
    else                    imem_inst_i = 32'hA000_0000 | pc_o;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_if(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                          input logic [31:0] pc4, input logic valid, input logic err);
    check({tag, ".pc"},    pc_o,                 pc);
    check({tag, ".inst"},  ifid_inst_o,          inst);
    check({tag, ".pc4"},   ifid_pc4_o,           pc4);
    check({tag, ".valid"}, {31'b0, ifid_valid_o}, {31'b0, valid});
    check({tag, ".err"},   {31'b0, fetch_err_o},  {31'b0, err});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;

    #12;
    check_if("reset", 32'h0, NOP, 32'h0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;

    // T1: sequential fetch from reset
    tick(); check_if("t1.e1", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 1'b0);
    tick(); check_if("t1.e2", 32'h8, 32'h2009_0007, 32'h8, 1'b1, 1'b0);
    tick(); check_if("t1.e3", 32'hC, 32'hA000_0008, 32'hC, 1'b1, 1'b0);
    tick(); check_if("t1.e4", 32'h10, 32'hA000_000C, 32'h10, 1'b1, 1'b0);

    // T2: three-cycle stall at 0x10
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check_if("t2.hold", 32'h10, 32'hA000_000C, 32'h10, 1'b1, 1'b0);
    end
    stall_i = 1'b0;
    tick(); check_if("t2.rel", 32'h14, 32'hA000_0010, 32'h14, 1'b1, 1'b0);

    // T5: single-cycle flush at 0x20
    tick(); tick(); tick();
    check_if("t5.pre", 32'h20, 32'hA000_001C, 32'h20, 1'b1, 1'b0);
    flush_i = 1'b1;
    tick(); check_if("t5.flush", 32'h24, NOP, 32'h0, 1'b0, 1'b0);
    flush_i = 1'b0;
    tick(); check_if("t5.resume", 32'h28, 32'hA000_0024, 32'h28, 1'b1, 1'b0);

    // flush together with stall: bubble but PC holds
    flush_i = 1'b1; stall_i = 1'b1;
    tick(); check_if("fs.hold", 32'h28, NOP, 32'h0, 1'b0, 1'b0);
    flush_i = 1'b0; stall_i = 1'b0;
    tick(); check_if("fs.resume", 32'h2C, 32'hA000_0028, 32'h2C, 1'b1, 1'b0);

    // T3: redirect overrides stall
    redirect_i = 1'b1; redirect_pc_i = 32'h40; stall_i = 1'b1;
    tick(); check_if("t3.redir", 32'h40, NOP, 32'h0, 1'b0, 1'b0);
    redirect_i = 1'b0; stall_i = 1'b0;
    tick(); check_if("t3.fetch", 32'h44, 32'hA000_0040, 32'h44, 1'b1, 1'b0);

    // T4c: sequential fetch running past the last word
    redirect_i = 1'b1; redirect_pc_i = 32'h3F8;
    tick(); check_if("t4c.redir", 32'h3F8, NOP, 32'h0, 1'b0, 1'b0);
    redirect_i = 1'b0;
    tick(); check_if("t4c.last", 32'h3FC, 32'hA000_03F8, 32'h3FC, 1'b1, 1'b0);
    tick(); check_if("t4c.err", 32'h3FC, NOP, 32'h0, 1'b0, 1'b1);
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    tick(); check_if("t4c.halt", 32'h3FC, NOP, 32'h0, 1'b0, 1'b1);
    redirect_i = 1'b0; stall_i = 1'b1;
    tick(); check_if("t4c.halt2", 32'h3FC, NOP, 32'h0, 1'b0, 1'b1);

    // T6: async reset mid-cycle while stalled in HALT
    #3 rst_n = 1'b0;
    #1 check_if("t6.async", 32'h0, NOP, 32'h0, 1'b0, 1'b0);
    stall_i = 1'b0;
    tick();
    #3 rst_n = 1'b1;
    tick(); check_if("t6.restart", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 1'b0);

    // T4a: misaligned redirect target
    redirect_i = 1'b1; redirect_pc_i = 32'h42;
    tick(); check_if("t4a.err", 32'h4, NOP, 32'h0, 1'b0, 1'b1);
    redirect_i = 1'b0;
    tick(); check_if("t4a.halt", 32'h4, NOP, 32'h0, 1'b0, 1'b1);

    // T4b: redirect past end of memory
    #3 rst_n = 1'b0;
    tick();
    #3 rst_n = 1'b1;
    tick(); check_if("t4b.run", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 1'b0);
    redirect_i = 1'b1; redirect_pc_i = 32'h400;
    tick(); check_if("t4b.err", 32'h4, NOP, 32'h0, 1'b0, 1'b1);
    redirect_i = 1'b0;
    tick(); check_if("t4b.halt", 32'h4, NOP, 32'h0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
